fetch_bridge: RTL and testbench

FETCH_BRIDGE -- requirements
Module: fetch_bridge

---
 rtl/fetch_bridge_pkg.sv | 18 +
 rtl/fetch_bridge_if.sv | 39 +++
 rtl/fetch_bridge_fifo.sv | 54 +++++
 rtl/fetch_bridge.sv | 165 ++++++++++++++++
 tb/tb_fetch_bridge.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_bridge_pkg.sv
// Shared definitions for the fetch bridge: FSM state encoding and the
// default width constants used by the interface and the bridge itself.
package fetch_bridge_pkg;

  localparam int DEFAULT_DATA_WIDTH      = 32;
  localparam int DEFAULT_ADDRESS_BITS    = 32;
  localparam int DEFAULT_MAX_OUTSTANDING = 4;

  // IDLE: no memory request pending
  // REQ: mem_req high, waiting for mem_ack
  // DRAIN: discarding returns that belong to fetches killed by a flush
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/fetch_bridge_if.sv
// Core-side fetch handshake and memory-side read bus of the fetch bridge.
// The master modport is the bridge's view; the slave modport is the view of
// whatever surrounds it (core plus memory).
interface fetch_bridge_if
  import fetch_bridge_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int ADDRESS_BITS = DEFAULT_ADDRESS_BITS
);

  logic                    flush;
  logic                    fetch_read;
  logic [ADDRESS_BITS-1:0] fetch_address_out;
  logic                    fetch_stall;
  logic                    fetch_ready;
  logic                    fetch_valid;
  logic [DATA_WIDTH-1:0]   fetch_data_in;
  logic [ADDRESS_BITS-1:0] fetch_address_in;
  logic                    mem_req;
  logic [ADDRESS_BITS-1:0] mem_addr;
  logic                    mem_ack;
  logic                    mem_rvalid;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  modport master (
    input  flush, fetch_read, fetch_address_out, fetch_stall,
    input  mem_ack, mem_rvalid, mem_rdata,
    output fetch_ready, fetch_valid, fetch_data_in, fetch_address_in,
    output mem_req, mem_addr
  );

  modport slave (
    output flush, fetch_read, fetch_address_out, fetch_stall,
    output mem_ack, mem_rvalid, mem_rdata,
    input  fetch_ready, fetch_valid, fetch_data_in, fetch_address_in,
    input  mem_req, mem_addr
  );

endinterface

// File: rtl/fetch_bridge_fifo.sv
// Small synchronous FIFO with a synchronous clear, used for both the
// in-flight address queue and the response queue of the fetch bridge.
// DEPTH must be a power of two and at least 2. Pushes into a full FIFO and
// pops from an empty FIFO are ignored; clear wins over push and pop.
module fetch_bridge_fifo
  import fetch_bridge_pkg::*;
#(
  parameter int WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH = DEFAULT_MAX_OUTSTANDING
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic [WIDTH-1:0] storage [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign count     = wr_ptr - rd_ptr;
  assign do_push   = push && (count != FULL_COUNT);
  assign do_pop    = pop && (count != '0);
  assign head_data = storage[rd_ptr[PW-1:0]];

  // Pointer update: reset and clear empty the FIFO, otherwise advance on push/pop
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because the pointers gate visibility
  always_ff @(posedge clock) begin
    if (do_push && !clear) storage[wr_ptr[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/fetch_bridge.sv
// Instruction fetch bridge between a core fetch port and an in-order memory
// read bus. Accepts up to MAX_OUTSTANDING fetches, issues them one at a time
// on mem_req/mem_ack, queues returns with their addresses, and drains returns
// of fetches killed by a flush.
// Optional feature: define FETCH_BRIDGE_BYPASS_EN to let a return that finds
// the response queue empty (and the core not stalled) reach the core in the
// same cycle instead of one cycle later.
module fetch_bridge
  import fetch_bridge_pkg::*;
#(
  parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
  parameter int ADDRESS_BITS    = DEFAULT_ADDRESS_BITS,
  parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
) (
  input logic            clock,
  input logic            reset,
  fetch_bridge_if.master bus
);

  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int RW = ADDRESS_BITS + DATA_WIDTH;

  state_t                  state_q, state_next;
  logic                    mem_req_q, mem_req_next;
  logic [ADDRESS_BITS-1:0] mem_addr_q, mem_addr_next;
  logic [CW-1:0]           outstanding_q, outstanding_next;
  logic [CW-1:0]           drop_q, drop_next;
  logic [CW-1:0]           addr_count;
  logic [CW-1:0]           resp_count;
  logic [ADDRESS_BITS-1:0] addr_head;
  logic [RW-1:0]           resp_head;
  logic                    accept_window;
  logic                    accept;
  logic                    ret_match;
  logic                    bypass_take;
  logic                    resp_push;
  logic                    resp_pop;
  logic                    resp_empty;
  logic                    core_pop;
  logic                    flush_load;

  assign accept_window = (state_q == IDLE) || ((state_q == REQ) && bus.mem_ack);
  assign bus.fetch_ready = reset && accept_window &&
                           (outstanding_q < CW'(MAX_OUTSTANDING)) && !bus.flush;
  assign accept     = bus.fetch_read && bus.fetch_ready;
  assign resp_empty = (resp_count == '0);
  assign ret_match  = bus.mem_rvalid && (state_q != DRAIN) && (addr_count != '0);
  assign flush_load = bus.flush && (state_q != DRAIN);

`ifdef FETCH_BRIDGE_BYPASS_EN
  assign bypass_take = ret_match && resp_empty && !bus.fetch_stall && !bus.flush;
`else
  assign bypass_take = 1'b0;
`endif

  assign resp_push       = ret_match && !bypass_take && !bus.flush;
  assign resp_pop        = !resp_empty && !bus.fetch_stall;
  assign bus.fetch_valid = !resp_empty || bypass_take;
  assign core_pop        = bus.fetch_valid && !bus.fetch_stall;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;

  fetch_bridge_fifo #(
    .WIDTH(ADDRESS_BITS),
    .DEPTH(MAX_OUTSTANDING)
  ) addr_fifo (
    .clock     (clock),
    .reset     (reset),
    .clear     (flush_load),
    .push      (accept),
    .push_data (bus.fetch_address_out),
    .pop       (ret_match),
    .head_data (addr_head),
    .count     (addr_count)
  );

  fetch_bridge_fifo #(
    .WIDTH(RW),
    .DEPTH(MAX_OUTSTANDING)
  ) resp_fifo (
    .clock     (clock),
    .reset     (reset),
    .clear     (bus.flush),
    .push      (resp_push),
    .push_data ({addr_head, bus.mem_rdata}),
    .pop       (resp_pop),
    .head_data (resp_head),
    .count     (resp_count)
  );

  // Core-facing response: bypassed return, else queue head, else zeros
  always_comb begin
    bus.fetch_data_in    = '0;
    bus.fetch_address_in = '0;
    if (bypass_take) begin
      bus.fetch_data_in    = bus.mem_rdata;
      bus.fetch_address_in = addr_head;
    end else if (!resp_empty) begin
      bus.fetch_data_in    = resp_head[DATA_WIDTH-1:0];
      bus.fetch_address_in = resp_head[RW-1:DATA_WIDTH];
    end
  end

  // Next state, memory request, outstanding and drop counters
  always_comb begin
    state_next       = state_q;
    mem_req_next     = mem_req_q;
    mem_addr_next    = mem_addr_q;
    drop_next        = drop_q;
    outstanding_next = outstanding_q + CW'(accept) - CW'(core_pop);
    if (flush_load) begin
      drop_next        = addr_count - CW'(ret_match);
      outstanding_next = addr_count - CW'(ret_match);
      mem_req_next     = mem_req_q && !bus.mem_ack;
      state_next       = ((addr_count - CW'(ret_match)) == '0) ? IDLE : DRAIN;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_next    = REQ;
            mem_req_next  = 1'b1;
            mem_addr_next = bus.fetch_address_out;
          end
        end
        REQ: begin
          if (bus.mem_ack) begin
            if (accept) begin
              mem_addr_next = bus.fetch_address_out;
            end else begin
              state_next   = IDLE;
              mem_req_next = 1'b0;
            end
          end
        end
        DRAIN: begin
          if (mem_req_q && bus.mem_ack) mem_req_next = 1'b0;
          if (bus.mem_rvalid && (drop_q != '0)) begin
            drop_next        = drop_q - CW'(1);
            outstanding_next = outstanding_q - CW'(1);
            if (drop_q == CW'(1)) state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State and counter registers with asynchronous active-low reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      state_q       <= state_next;
      mem_req_q     <= mem_req_next;
      mem_addr_q    <= mem_addr_next;
      outstanding_q <= outstanding_next;
      drop_q        <= drop_next;
    end
  end

endmodule

// File: tb/tb_fetch_bridge.sv
// Directed self-checking bench for fetch_bridge in its default build
// (one-cycle response latency). Returned responses are predicted in a
// scoreboard queue when the memory return is driven and compared when the
// bridge presents them to the core.
module tb_fetch_bridge;

  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [63:0] expq [$];

  // Free-running 10 ns clock
  always #5 clock = ~clock;

  fetch_bridge_if bus ();

  fetch_bridge dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before end of test");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic rd, input logic [31:0] addr,
                               input logic stall, input logic fl,
                               input logic ack, input logic rv,
                               input logic [31:0] rdata);
    bus.fetch_read        = rd;
    bus.fetch_address_out = addr;
    bus.fetch_stall       = stall;
    bus.flush             = fl;
    bus.mem_ack           = ack;
    bus.mem_rvalid        = rv;
    bus.mem_rdata         = rdata;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic expectResponse(input string tag);
    logic [63:0] exp_item;
    exp_item = (expq.size() != 0) ? expq[0] : 64'hDEAD_BEEF_DEAD_BEEF;
    checkOutput({tag, "_valid"}, 64'(bus.fetch_valid), 64'd1);
    checkOutput({tag, "_addr"}, 64'(bus.fetch_address_in), 64'(exp_item[63:32]));
    checkOutput({tag, "_data"}, 64'(bus.fetch_data_in), 64'(exp_item[31:0]));
    if (!bus.fetch_stall && expq.size() != 0) void'(expq.pop_front());
  endtask

  initial begin
    reset = 1'b0;
    bus.fetch_read = 1'b0; bus.fetch_address_out = '0; bus.fetch_stall = 1'b0;
    bus.flush = 1'b0; bus.mem_ack = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    #2;
    checkOutput("rst_ready", 64'(bus.fetch_ready), 64'd0);
    checkOutput("rst_valid", 64'(bus.fetch_valid), 64'd0);
    checkOutput("rst_mem_req", 64'(bus.mem_req), 64'd0);
    checkOutput("rst_data", 64'(bus.fetch_data_in), 64'd0);
    checkOutput("rst_addr", 64'(bus.fetch_address_in), 64'd0);
    tick();
    tick();
    reset = 1'b1;

    // Single fetch: accept, ack, return two cycles later, response next cycle
    applyStimulus(1, 32'h0, 0, 0, 0, 0, 32'h0);
    checkOutput("single_ready", 64'(bus.fetch_ready), 64'd1);
    tick();
    applyStimulus(0, 32'h0, 0, 0, 1, 0, 32'h0);
    checkOutput("single_mem_req", 64'(bus.mem_req), 64'd1);
    checkOutput("single_mem_addr", 64'(bus.mem_addr), 64'h0);
    tick();
    applyStimulus(0, 32'h0, 0, 0, 0, 0, 32'h0);
    checkOutput("single_req_drop", 64'(bus.mem_req), 64'd0);
    tick();
    applyStimulus(0, 32'h0, 0, 0, 0, 1, 32'h0000_0013);
    expq.push_back({32'h0, 32'h0000_0013});
    checkOutput("single_latency", 64'(bus.fetch_valid), 64'd0);
    tick();
    applyStimulus(0, 32'h0, 0, 0, 0, 0, 32'h0);
    expectResponse("single_resp");
    tick();

    // Back-to-back requests fill the outstanding limit
    applyStimulus(1, 32'h14, 0, 0, 0, 0, 32'h0);
    checkOutput("b2b_ready0", 64'(bus.fetch_ready), 64'd1);
    tick();
    applyStimulus(1, 32'h18, 0, 0, 1, 0, 32'h0);
    checkOutput("b2b_ready1", 64'(bus.fetch_ready), 64'd1);
    checkOutput("b2b_addr1", 64'(bus.mem_addr), 64'h14);
    tick();
    applyStimulus(1, 32'h1C, 0, 0, 1, 0, 32'h0);
    checkOutput("b2b_addr2", 64'(bus.mem_addr), 64'h18);
    tick();
    applyStimulus(1, 32'h20, 0, 0, 1, 0, 32'h0);
    checkOutput("b2b_addr3", 64'(bus.mem_addr), 64'h1C);
    tick();
    applyStimulus(1, 32'h24, 0, 0, 1, 0, 32'h0);
    checkOutput("b2b_full_ready", 64'(bus.fetch_ready), 64'd0);
    checkOutput("b2b_addr4", 64'(bus.mem_addr), 64'h20);
    checkOutput("b2b_req4", 64'(bus.mem_req), 64'd1);
    tick();
    applyStimulus(1, 32'h24, 0, 0, 0, 1, 32'h00A0_0093);
    expq.push_back({32'h14, 32'h00A0_0093});
    checkOutput("full_ready_a", 64'(bus.fetch_ready), 64'd0);
    checkOutput("full_valid_a", 64'(bus.fetch_valid), 64'd0);
    tick();

    // Stall with queued responses: outputs hold, then drain in order
    applyStimulus(1, 32'h24, 1, 0, 0, 1, 32'h00B0_0113);
    expq.push_back({32'h18, 32'h00B0_0113});
    expectResponse("stall_first");
    checkOutput("full_ready_b", 64'(bus.fetch_ready), 64'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 32'h24, 1, 0, 0, 0, 32'h0);
      expectResponse("stall_hold");
      checkOutput("stall_ready", 64'(bus.fetch_ready), 64'd0);
      tick();
    end
    applyStimulus(1, 32'h24, 0, 0, 0, 0, 32'h0);
    expectResponse("pop_14");
    checkOutput("pop_ready_low", 64'(bus.fetch_ready), 64'd0);
    tick();
    applyStimulus(1, 32'h24, 0, 0, 0, 0, 32'h0);
    expectResponse("pop_18");
    checkOutput("pop_ready_high", 64'(bus.fetch_ready), 64'd1);
    tick();

    // Build three in-flight fetches plus one queued response, then flush
    applyStimulus(1, 32'h28, 0, 0, 1, 0, 32'h0);
    checkOutput("pre_flush_ready", 64'(bus.fetch_ready), 64'd1);
    checkOutput("pre_flush_addr", 64'(bus.mem_addr), 64'h24);
    tick();
    applyStimulus(0, 32'h0, 1, 0, 0, 1, 32'h00C0_0193);
    checkOutput("pre_flush_req", 64'(bus.mem_req), 64'd1);
    checkOutput("pre_flush_addr2", 64'(bus.mem_addr), 64'h28);
    tick();
    applyStimulus(0, 32'h0, 1, 1, 0, 0, 32'h0);
    checkOutput("flush_valid_now", 64'(bus.fetch_valid), 64'd1);
    checkOutput("flush_ready", 64'(bus.fetch_ready), 64'd0);
    tick();
    applyStimulus(0, 32'h0, 0, 0, 1, 0, 32'h0);
    checkOutput("drain_valid", 64'(bus.fetch_valid), 64'd0);
    checkOutput("drain_ready", 64'(bus.fetch_ready), 64'd0);
    checkOutput("drain_req_held", 64'(bus.mem_req), 64'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 32'h40, 0, 0, 0, 1, 32'h0BAD_0000 + 32'(i));
      checkOutput("drain_ready_rv", 64'(bus.fetch_ready), 64'd0);
      checkOutput("drain_valid_rv", 64'(bus.fetch_valid), 64'd0);
      checkOutput("drain_req_rv", 64'(bus.mem_req), 64'd0);
      tick();
    end
    applyStimulus(1, 32'h40, 0, 0, 0, 0, 32'h0);
    checkOutput("post_drain_ready", 64'(bus.fetch_ready), 64'd1);
    tick();

    // Reset in REQ with two outstanding fetches
    applyStimulus(1, 32'h44, 0, 0, 1, 0, 32'h0);
    checkOutput("rst2_ready", 64'(bus.fetch_ready), 64'd1);
    tick();
    applyStimulus(0, 32'h0, 0, 0, 0, 0, 32'h0);
    checkOutput("rst2_req_before", 64'(bus.mem_req), 64'd1);
    checkOutput("rst2_addr_before", 64'(bus.mem_addr), 64'h44);
    reset = 1'b0;
    #1;
    checkOutput("rst2_req", 64'(bus.mem_req), 64'd0);
    checkOutput("rst2_valid", 64'(bus.fetch_valid), 64'd0);
    checkOutput("rst2_ready_low", 64'(bus.fetch_ready), 64'd0);
    checkOutput("rst2_mem_addr", 64'(bus.mem_addr), 64'h0);
    tick();
    reset = 1'b1;
    applyStimulus(0, 32'h0, 0, 0, 0, 1, 32'h0000_0BAD);
    checkOutput("stray_valid_now", 64'(bus.fetch_valid), 64'd0);
    tick();
    applyStimulus(0, 32'h0, 0, 0, 0, 0, 32'h0);
    checkOutput("stray_valid_next", 64'(bus.fetch_valid), 64'd0);
    checkOutput("stray_ready", 64'(bus.fetch_ready), 64'd1);
    tick();

    // Flush with nothing outstanding stays in IDLE
    applyStimulus(0, 32'h0, 0, 1, 0, 0, 32'h0);
    checkOutput("idle_flush_ready", 64'(bus.fetch_ready), 64'd0);
    tick();
    applyStimulus(1, 32'h50, 0, 0, 0, 0, 32'h0);
    checkOutput("idle_flush_after", 64'(bus.fetch_ready), 64'd1);
    tick();
    applyStimulus(0, 32'h0, 0, 0, 1, 0, 32'h0);
    checkOutput("idle_flush_req", 64'(bus.mem_req), 64'd1);
    checkOutput("idle_flush_addr", 64'(bus.mem_addr), 64'h50);
    tick();
    applyStimulus(0, 32'h0, 0, 0, 0, 0, 32'h0);

    checkOutput("scoreboard_empty", 64'(expq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
